// File: rtl/gouram_trace_drain.sv
// gouram_trace_drain: buffers 160-bit tracer records in a FIFO and streams each
// record out as a 6-beat 32-bit packet (header + 5 data words). When the FIFO
// is full, records are dropped and the drops are counted.
module gouram_trace_drain #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [159:0]                trace_data_i,
  input  logic                        trace_capture_enable_i,
  input  logic                        trace_ready_i,
  output logic [31:0]                 m_data_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic                        m_last_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [31:0]                 overflow_total_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [159:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_beat;
  logic [2:0]    w_beat_nxt;
  logic [31:0]   r_data;
  logic [31:0]   w_data_nxt;
  logic          r_valid;
  logic          w_valid_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic          w_load;
  logic [7:0]    r_seq;
  logic [15:0]   r_drop_pend;
  logic [31:0]   r_ovf;

  logic          w_event;
  logic          w_full;
  logic          w_hs;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [159:0]  w_head;
  logic [31:0]   w_hdr;

  assign w_event = trace_capture_enable_i & trace_ready_i;
  assign w_full  = (r_count == LW'(FIFO_DEPTH));
  assign w_hs    = (r_state == S_SEND) & r_valid & m_ready_i;
  assign w_pop   = w_hs & (r_beat == 3'd5);
  assign w_drop  = w_event & w_full & ~w_pop;
  assign w_push  = w_event & ~w_drop;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_hdr   = {8'hA5, r_seq, r_drop_pend};

  assign m_data_o         = r_data;
  assign m_valid_o        = r_valid;
  assign m_last_o         = r_last;
  assign fifo_level_o     = r_count;
  assign overflow_total_o = r_ovf;

  // Selects data word idx (0..4) of a record.
  function automatic logic [31:0] rec_word(input logic [159:0] rec, input logic [2:0] idx);
    case (idx)
      3'd0:    rec_word = rec[31:0];
      3'd1:    rec_word = rec[63:32];
      3'd2:    rec_word = rec[95:64];
      3'd3:    rec_word = rec[127:96];
      default: rec_word = rec[159:128];
    endcase
  endfunction

  // Record storage; contents need no reset because pointers/count gate all reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= trace_data_i;
  end

  // FIFO pointers, occupancy and drop accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_drop_pend <= '0;
      r_ovf       <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
      if (w_load)
        r_drop_pend <= {15'd0, w_drop};
      else if (w_drop && (r_drop_pend != 16'hFFFF))
        r_drop_pend <= r_drop_pend + 16'd1;
      if (w_drop && (r_ovf != 32'hFFFF_FFFF))
        r_ovf <= r_ovf + 32'd1;
    end
  end

  // FSM state and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_seq   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      if (w_load) r_seq <= r_seq + 8'd1;
    end
  end

  // Next-state and next-beat selection; a header load happens from IDLE or back-to-back after beat 5.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
          w_beat_nxt  = 3'd0;
          w_data_nxt  = w_hdr;
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (r_beat != 3'd5) begin
            w_beat_nxt = r_beat + 3'd1;
            w_data_nxt = rec_word(w_head, r_beat);
            w_last_nxt = (r_beat == 3'd4);
          end else if ((r_count > LW'(1)) || w_event) begin
            w_load     = 1'b1;
            w_beat_nxt = 3'd0;
            w_data_nxt = w_hdr;
            w_last_nxt = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_beat_nxt  = 3'd0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gouram_trace_drain.sv
// Self-checking bench for gouram_trace_drain: directed table, corner sequences,
// and randomized traffic against a queue-based packet model.
module tb_gouram_trace_drain;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [159:0] trace_data_i = '0;
  logic         trace_capture_enable_i = 1'b0;
  logic         trace_ready_i = 1'b0;
  logic [31:0]  m_data_o;
  logic         m_valid_o;
  logic         m_ready_i = 1'b0;
  logic         m_last_o;
  logic [2:0]   fifo_level_o;
  logic [31:0]  overflow_total_o;

  gouram_trace_drain #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .trace_data_i(trace_data_i),
    .trace_capture_enable_i(trace_capture_enable_i),
    .trace_ready_i(trace_ready_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_last_o(m_last_o), .fifo_level_o(fifo_level_o),
    .overflow_total_o(overflow_total_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: queue of held records plus position within the current packet.
  logic [159:0] mq[$];
  bit           m_busy;
  int           m_beat;
  logic [31:0]  m_hdr;
  logic [7:0]   m_seq;
  logic [15:0]  m_dp;
  logic [31:0]  m_ovf;
  bit           m_loaded;
  logic [31:0]  dut_hdr_log[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_beat = 0; m_hdr = '0; m_seq = '0; m_dp = '0; m_ovf = '0;
    m_loaded = 0;
    dut_hdr_log.delete();
  endtask

  task automatic model_step(input bit ev, input logic [159:0] d, input bit mr);
    bit hs, pop, full, drop, push, load;
    hs   = m_busy && mr;
    pop  = hs && (m_beat == 5);
    full = (mq.size() == DEPTH);
    drop = ev && full && !pop;
    push = ev && !drop;
    load = 0;
    if (!m_busy) begin
      if (mq.size() > 0) begin load = 1; m_busy = 1; m_beat = 0; end
    end else if (hs) begin
      if (m_beat < 5) m_beat++;
      else begin
        void'(mq.pop_front());
        if (mq.size() > 0 || push) begin load = 1; m_beat = 0; end
        else begin m_busy = 0; m_beat = 0; end
      end
    end
    if (push) mq.push_back(d);
    if (load) begin
      m_hdr = {8'hA5, m_seq, m_dp};
      m_seq = m_seq + 8'd1;
      m_dp  = drop ? 16'd1 : 16'd0;
    end else if (drop && m_dp != 16'hFFFF) m_dp = m_dp + 16'd1;
    if (drop && m_ovf != 32'hFFFF_FFFF) m_ovf = m_ovf + 32'd1;
    m_loaded = load;
  endtask

  task automatic compare_all();
    logic [159:0] h;
    logic [31:0]  ed;
    check("valid", 32'(m_valid_o), 32'(m_busy));
    check("last", 32'(m_last_o), 32'(m_busy && m_beat == 5));
    check("level", 32'(fifo_level_o), 32'(mq.size()));
    check("ovf_total", overflow_total_o, m_ovf);
    if (m_busy) begin
      if (m_beat == 0) ed = m_hdr;
      else begin
        h  = mq[0];
        ed = h[32*(m_beat-1) +: 32];
      end
      check("data", m_data_o, ed);
    end
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, compare at next negedge.
  task automatic cyc(input bit cap, input bit tr, input logic [159:0] d, input bit mr);
    trace_capture_enable_i = cap;
    trace_ready_i          = tr;
    trace_data_i           = d;
    m_ready_i              = mr;
    @(posedge clk);
    model_step(cap & tr, d, mr);
    @(negedge clk);
    if (m_loaded) dut_hdr_log.push_back(m_data_o);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    trace_capture_enable_i = 0; trace_ready_i = 0; m_ready_i = 0;
    #1;
    check("rst_valid", 32'(m_valid_o), 32'd0);
    check("rst_last", 32'(m_last_o), 32'd0);
    check("rst_data", m_data_o, 32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    check("rst_ovf", overflow_total_o, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [159:0] rnd160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    bit          cap;
    bit          exp_valid;
    bit          exp_last;
    logic [31:0] exp_data;
    int          exp_level;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [159:0] rec;
    int nz;
    bit found;

    // Directed single-record timeline: row i gives inputs and expected outputs of one cycle.
    rec = 160'h0000000400000003000000020000000100000000;
    tbl[0] = '{1, 0, 0, 32'h0, 0};
    tbl[1] = '{0, 0, 0, 32'h0, 1};
    tbl[2] = '{0, 1, 0, 32'hA500_0000, 1};
    tbl[3] = '{0, 1, 0, 32'h0000_0000, 1};
    tbl[4] = '{0, 1, 0, 32'h0000_0001, 1};
    tbl[5] = '{0, 1, 0, 32'h0000_0002, 1};
    tbl[6] = '{0, 1, 0, 32'h0000_0003, 1};
    tbl[7] = '{0, 1, 1, 32'h0000_0004, 1};
    tbl[8] = '{0, 0, 0, 32'h0, 0};

    do_reset();
    for (int i = 0; i < 9; i++) cyc(0, 0, '0, 1);
    for (int i = 0; i < 9; i++) begin
      check("tbl_valid", 32'(m_valid_o), 32'(tbl[i].exp_valid));
      check("tbl_last", 32'(m_last_o), 32'(tbl[i].exp_last));
      check("tbl_level", 32'(fifo_level_o), 32'(tbl[i].exp_level));
      if (tbl[i].exp_valid) check("tbl_data", m_data_o, tbl[i].exp_data);
      cyc(tbl[i].cap, tbl[i].cap, rec, 1);
    end

    // Random stalls, 20 spaced records; seq must count headers from 0.
    do_reset();
    for (int r = 0; r < 20; r++) begin
      cyc(1, 1, rnd160(), 1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(10, 20)); g++)
        cyc(0, 1'($urandom_range(0, 1)), rnd160(), 1'($urandom_range(0, 1)));
    end
    for (int g = 0; g < 200; g++) cyc(0, 0, '0, 1'($urandom_range(0, 1)));
    check("rand_hdr_count", 32'(dut_hdr_log.size()), 32'd20);
    for (int i = 0; i < dut_hdr_log.size(); i++)
      check("rand_seq", 32'(dut_hdr_log[i][23:16]), 32'(i));

    // Overflow: 7 back-to-back records with the sink stalled.
    do_reset();
    for (int r = 0; r < 7; r++) cyc(1, 1, rnd160(), 0);
    cyc(0, 0, '0, 0);
    check("ovf_level", 32'(fifo_level_o), 32'd4);
    check("ovf_total3", overflow_total_o, 32'd3);
    for (int g = 0; g < 40; g++) cyc(0, 0, '0, 1);
    check("ovf_hdr_count", 32'(dut_hdr_log.size()), 32'd4);
    if (dut_hdr_log.size() == 4) begin
      check("ovf_hdr0", dut_hdr_log[0], 32'hA500_0000);
      check("ovf_hdr1", dut_hdr_log[1], 32'hA501_0003);
      check("ovf_hdr2_drops", 32'(dut_hdr_log[2][15:0]), 32'd0);
      check("ovf_hdr3_drops", 32'(dut_hdr_log[3][15:0]), 32'd0);
    end

    // Full FIFO with a record event exactly on the beat-5 handshake.
    do_reset();
    for (int r = 0; r < 4; r++) cyc(1, 1, rnd160(), 0);
    cyc(0, 0, '0, 0);
    found = 0;
    for (int g = 0; g < 20 && !found; g++) begin
      if (m_busy && m_beat == 5) begin
        found = 1;
        cyc(1, 1, rnd160(), 1);
        check("full_pop_level", 32'(fifo_level_o), 32'd4);
        check("full_pop_ovf", overflow_total_o, 32'd0);
        check("full_pop_valid", 32'(m_valid_o), 32'd1);
        check("full_pop_hdr", 32'(m_data_o[31:24]), 32'hA5);
      end else cyc(0, 0, '0, 1);
    end
    check("full_pop_reached", 32'(found), 32'd1);
    for (int g = 0; g < 40; g++) cyc(0, 0, '0, 1);

    // Reset during beat 3 with two records queued.
    do_reset();
    cyc(1, 1, rnd160(), 0);
    cyc(1, 1, rnd160(), 0);
    found = 0;
    for (int g = 0; g < 20 && !found; g++) begin
      if (m_busy && m_beat == 3) found = 1;
      else cyc(0, 0, '0, 1);
    end
    check("mid_rst_reached", 32'(found), 32'd1);
    do_reset();
    for (int g = 0; g < 10; g++) cyc(0, 0, '0, 1);
    check("post_rst_idle", 32'(m_valid_o), 32'd0);
    cyc(1, 1, rnd160(), 1);
    cyc(0, 0, '0, 1);
    check("post_rst_hdr", m_data_o, 32'hA500_0000);
    for (int g = 0; g < 10; g++) cyc(0, 0, '0, 1);

    // 260 spaced records: seq wraps on the 257th header, no drops.
    do_reset();
    for (int r = 0; r < 260; r++) begin
      cyc(1, 1, rnd160(), 1);
      for (int g = 0; g < 7; g++) cyc(0, 0, '0, 1);
    end
    for (int g = 0; g < 10; g++) cyc(0, 0, '0, 1);
    check("wrap_hdr_count", 32'(dut_hdr_log.size()), 32'd260);
    if (dut_hdr_log.size() == 260) begin
      check("wrap_seq255", 32'(dut_hdr_log[255][23:16]), 32'hFF);
      check("wrap_seq256", 32'(dut_hdr_log[256][23:16]), 32'h00);
      nz = 0;
      foreach (dut_hdr_log[i]) if (dut_hdr_log[i][15:0] != 16'd0) nz++;
      check("wrap_drops_zero", 32'(nz), 32'd0);
    end

    // Heavy random traffic with drops and stalls.
    do_reset();
    for (int g = 0; g < 1500; g++)
      cyc(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 80), rnd160(),
          1'($urandom_range(0, 1)));
    for (int g = 0; g < 100; g++) cyc(0, 0, '0, 1);
    check("heavy_drained", 32'(fifo_level_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
